control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for a multi-cycle CPU: sequences T0..T7 per opcode,
// drives the control strobe bus, and counts retired instructions.
module control_sequencer #(
    parameter int OPW      = 5,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [OPW-1:0]   ir_opcode,
    input  logic             mem_ready,
    output logic [23:0]      ctrl,
    output logic [OPW-1:0]   alu_op,
    output logic [3:0]       step,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int PCOUT   = 0;
    localparam int PCIN    = 1;
    localparam int MARIN   = 2;
    localparam int MDRIN   = 3;
    localparam int MDROUT  = 4;
    localparam int IRIN    = 5;
    localparam int INCPC   = 6;
    localparam int READ    = 7;
    localparam int WRITE   = 8;
    localparam int ZIN     = 9;
    localparam int ZLOWOUT = 10;
    localparam int ZHIOUT  = 11;
    localparam int YIN     = 12;
    localparam int GRA     = 13;
    localparam int GRB     = 14;
    localparam int GRC     = 15;
    localparam int RIN     = 16;
    localparam int ROUT    = 17;
    localparam int BAOUT   = 18;
    localparam int COUT    = 19;
    localparam int HIIN    = 20;
    localparam int LOIN    = 21;
    localparam int HALTED  = 22;
    localparam int STALL   = 23;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    typedef enum logic [3:0] {
        S_DEFAULT = 4'd0,
        S_T0      = 4'd1,
        S_T1      = 4'd2,
        S_T2      = 4'd3,
        S_T3      = 4'd4,
        S_T4      = 4'd5,
        S_T5      = 4'd6,
        S_T6      = 4'd7,
        S_T7      = 4'd8,
        S_HALT    = 4'd15
    } state_t;

    state_t     state;
    logic [3:0] step_inc;
    logic       is_ld, is_ldi, is_st, is_rtype, is_mul, is_nop, is_halt;
    logic       is_mem_fam, is_alu_fam, is_legal;
    logic       mem_step, stalled, seq_end;

    always_comb begin
        is_ld      = (ir_opcode == OP_LD);
        is_ldi     = (ir_opcode == OP_LDI);
        is_st      = (ir_opcode == OP_ST);
        is_rtype   = (ir_opcode == OP_ADD) || (ir_opcode == OP_SUB) ||
                     (ir_opcode == OP_AND) || (ir_opcode == OP_OR);
        is_mul     = (ir_opcode == OP_MUL);
        is_nop     = (ir_opcode == OP_NOP);
        is_halt    = (ir_opcode == OP_HALT);
        is_mem_fam = is_ld || is_ldi || is_st;
        is_alu_fam = is_rtype || is_mul;
        is_legal   = is_mem_fam || is_alu_fam || is_nop || is_halt;
        mem_step   = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
        stalled    = (MEM_WAIT != 0) && mem_step && !mem_ready;
        step_inc   = state + 4'd1;
        // Unknown opcode/step combinations retire rather than wander into undefined steps.
        case (state)
            S_T2:       seq_end = !is_legal || is_nop;
            S_T3, S_T4: seq_end = !(is_mem_fam || is_alu_fam);
            S_T5:       seq_end = is_ldi || is_rtype || !(is_ld || is_st || is_mul);
            S_T6:       seq_end = !(is_ld || is_st);
            S_T7:       seq_end = 1'b1;
            default:    seq_end = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= S_DEFAULT;
            instr_count <= '0;
        end else begin
            case (state)
                S_DEFAULT: if (run) state <= S_T0;
                S_HALT:    state <= S_HALT;
                S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                    if (!stalled) begin
                        if (state == S_T2 && is_halt) begin
                            state       <= S_HALT;
                            instr_count <= instr_count + CNT_W'(1);
                        end else if (seq_end) begin
                            state       <= run ? S_T0 : S_DEFAULT;
                            instr_count <= instr_count + CNT_W'(1);
                        end else begin
                            state <= state_t'(step_inc);
                        end
                    end
                end
                default:   state <= S_DEFAULT;
            endcase
        end
    end

    // Strobe decode: Moore in state/opcode, plus the memory-wait stall qualifier.
    always_comb begin
        ctrl   = '0;
        alu_op = '0;
        case (state)
            S_T0: begin
                ctrl[PCOUT] = 1'b1; ctrl[MARIN] = 1'b1; ctrl[INCPC] = 1'b1; ctrl[ZIN] = 1'b1;
                alu_op      = OP_ADD;
            end
            S_T1: begin
                ctrl[ZLOWOUT] = 1'b1; ctrl[READ] = 1'b1; ctrl[MDRIN] = 1'b1;
                ctrl[PCIN]    = !stalled;
                ctrl[STALL]   = stalled;
            end
            S_T2: begin
                ctrl[MDROUT] = 1'b1; ctrl[IRIN] = 1'b1;
            end
            S_T3: begin
                if (is_mem_fam) begin
                    ctrl[GRB] = 1'b1; ctrl[BAOUT] = 1'b1; ctrl[YIN] = 1'b1;
                end else if (is_alu_fam) begin
                    ctrl[GRB] = 1'b1; ctrl[ROUT] = 1'b1; ctrl[YIN] = 1'b1;
                end
            end
            S_T4: begin
                if (is_mem_fam) begin
                    ctrl[COUT] = 1'b1; ctrl[ZIN] = 1'b1;
                    alu_op     = OP_ADD;
                end else if (is_alu_fam) begin
                    ctrl[GRC] = 1'b1; ctrl[ROUT] = 1'b1; ctrl[ZIN] = 1'b1;
                    alu_op    = ir_opcode;
                end
            end
            S_T5: begin
                if (is_ld || is_st) begin
                    ctrl[ZLOWOUT] = 1'b1; ctrl[MARIN] = 1'b1;
                end else if (is_ldi || is_rtype) begin
                    ctrl[ZLOWOUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[RIN] = 1'b1;
                end else if (is_mul) begin
                    ctrl[ZLOWOUT] = 1'b1; ctrl[LOIN] = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    ctrl[READ] = 1'b1; ctrl[MDRIN] = 1'b1; ctrl[STALL] = stalled;
                end else if (is_st) begin
                    ctrl[GRA] = 1'b1; ctrl[ROUT] = 1'b1; ctrl[MDRIN] = 1'b1;
                end else if (is_mul) begin
                    ctrl[ZHIOUT] = 1'b1; ctrl[HIIN] = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    ctrl[MDROUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[RIN] = 1'b1;
                end else if (is_st) begin
                    ctrl[WRITE] = 1'b1; ctrl[STALL] = stalled;
                end
            end
            S_HALT:  ctrl[HALTED] = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign step    = state;
    assign illegal = (state == S_T2) && !is_legal;

endmodule
